// File: rtl/mem_initiator.sv
// Single-outstanding command initiator for the 32x32 memory with error counting.
// Optional macro MEM_INIT_WR_RSP_EN: successful writes also return a response.
module mem_initiator #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_full,
  input  logic              mem_empty,
  input  logic              mem_half_full,
  output logic              half_full,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RD, RSP} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              reject;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign accept = cmd_valid && cmd_ready;
  assign reject = cmd_we ? mem_full : mem_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state)
      IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid && rst_n) begin
          if (reject)      state_nxt = RSP;
          else if (cmd_we) state_nxt = WRITE;
          else             state_nxt = READ;
        end
      end
      WRITE: begin
        mem_wr_en   = 1'b1;
        mem_addr    = addr_q;
        mem_wr_data = wdata_q;
`ifdef MEM_INIT_WR_RSP_EN
        state_nxt   = RSP;
`else
        state_nxt   = IDLE;
`endif
      end
      READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q;
        state_nxt = WAIT_RD;
      end
      WAIT_RD: state_nxt = RSP;
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response payload only reaches the pins while a response is presented.
  assign rsp_data = rsp_valid ? rdata_q : '0;
  assign rsp_err  = rsp_valid & err_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      rdata_q <= '0;
    end else if (state == WAIT_RD) begin
      rdata_q <= mem_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt   <= 8'd0;
      half_full <= 1'b0;
    end else begin
      half_full <= mem_half_full;
      if (accept) begin
        err_q <= reject;
        if (reject) err_cnt <= sat_inc(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: vector table plus hand sequences for
// reset, backpressure, error-count saturation and reset during a read.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        mem_wr_en, mem_rd_en;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_data_out = 32'd0;
  logic        mem_full, mem_empty, mem_half_full, half_full;
  logic [7:0]  err_cnt;

  int n_pass = 0;
  int n_total = 0;
  int both_seen = 0;
  int idle_bus_seen = 0;
  int wr_seen = 0;

  logic [31:0] model [32];

  mem_initiator #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_data_out(mem_data_out),
    .mem_full(mem_full), .mem_empty(mem_empty), .mem_half_full(mem_half_full),
    .half_full(half_full), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural memory: read data appears the cycle after mem_rd_en.
  always @(posedge clk) begin
    if (mem_wr_en === 1'b1) begin
      model[mem_addr] <= mem_wr_data;
      wr_seen <= wr_seen + 1;
    end
    if (mem_rd_en === 1'b1) mem_data_out <= model[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1 && mem_rd_en === 1'b1) both_seen++;
    if (mem_wr_en === 1'b0 && mem_rd_en === 1'b0 &&
        (mem_addr !== 5'd0 || mem_wr_data !== 32'd0)) idle_bus_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {26'd0, cmd_ready, rsp_valid, rsp_err, mem_wr_en, mem_rd_en, half_full}, 32'd0);
    chk({name, "_rsp_data"}, rsp_data, 32'd0);
    chk({name, "_bus"}, {27'd0, mem_addr} | mem_wr_data, 32'd0);
    chk({name, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        full;
    logic        empty;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input int idx, input vec_t v);
    int rsp_k = 0, rdy_k = 0, wr_k = 0, rd_k = 0;
    int exp_wr_k, exp_rd_k, exp_rsp_k, exp_rdy_k;
    logic [31:0] saddr = 32'd0, rdata = 32'd0;
    logic        rerr = 1'b0;
    string       p = $sformatf("v%0d", idx);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata;
    mem_full = v.full; mem_empty = v.empty; rsp_ready = 1'b1;
    chk({p, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 8 && rsp_k == 0 && rdy_k == 0; k++) begin
      @(negedge clk);
      if (mem_wr_en === 1'b1 && wr_k == 0) begin wr_k = k; saddr = {27'd0, mem_addr}; end
      if (mem_rd_en === 1'b1 && rd_k == 0) begin rd_k = k; saddr = {27'd0, mem_addr}; end
      if (rsp_valid === 1'b1) begin rsp_k = k; rdata = rsp_data; rerr = rsp_err; end
      else if (cmd_ready === 1'b1) rdy_k = k;
    end
    exp_wr_k  = (v.we && !v.full) ? 1 : 0;
    exp_rd_k  = (!v.we && !v.empty) ? 1 : 0;
    exp_rdy_k = 0;
    if (v.we && !v.full) begin
`ifdef MEM_INIT_WR_RSP_EN
      exp_rsp_k = 2;
`else
      exp_rsp_k = 0;
      exp_rdy_k = 2;
`endif
    end else if (v.exp_err) exp_rsp_k = 1;
    else exp_rsp_k = 3;
    chk({p, "_wr_cycle"}, wr_k, exp_wr_k);
    chk({p, "_rd_cycle"}, rd_k, exp_rd_k);
    chk({p, "_rsp_cycle"}, rsp_k, exp_rsp_k);
    chk({p, "_ready_cycle"}, rdy_k, exp_rdy_k);
    if (exp_wr_k != 0 || exp_rd_k != 0) chk({p, "_mem_addr"}, saddr, {27'd0, v.addr});
    if (exp_rsp_k != 0) begin
      chk({p, "_rsp_err"}, {31'd0, rerr}, {31'd0, v.exp_err});
      chk({p, "_rsp_data"}, rdata, v.exp_data);
    end
    chk({p, "_err_cnt"}, {24'd0, err_cnt}, {24'd0, v.exp_cnt});
    if (rsp_k != 0) @(posedge clk);
  endtask

  initial begin
    logic [31:0] held;
    int          wr_before, k;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0,        8'd0};
    vecs[1] = '{1'b0, 5'd5,  32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 8'd0};
    vecs[2] = '{1'b0, 5'd3,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        8'd1};
    vecs[3] = '{1'b1, 5'd7,  32'h11111111, 1'b1, 1'b0, 1'b1, 32'h0,        8'd2};
    vecs[4] = '{1'b1, 5'd31, 32'hA5A55A5A, 1'b0, 1'b0, 1'b0, 32'h0,        8'd2};
    vecs[5] = '{1'b0, 5'd31, 32'h0,        1'b0, 1'b0, 1'b0, 32'hA5A55A5A, 8'd2};
    vecs[6] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h0,        8'd2};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 8'd2};
    vecs[8] = '{1'b1, 5'd12, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0,        8'd2};

    // Reset with a pending write command and half-full asserted.
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'd9; cmd_wdata = 32'h55;
    rsp_ready = 1'b1; mem_full = 1'b0; mem_empty = 1'b0; mem_half_full = 1'b1;
    @(negedge clk); chk_all_zero("reset_c1");
    @(negedge clk); chk_all_zero("reset_c2");
    chk("reset_no_write", wr_seen, 0);
    cmd_valid = 1'b0; rst_n = 1'b1; mem_half_full = 1'b0;
    #1 chk("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // half_full lags its input by one cycle.
    mem_half_full = 1'b1;
    #1 chk("half_full_lag", {31'd0, half_full}, 32'd0);
    @(negedge clk) chk("half_full_set", {31'd0, half_full}, 32'd1);
    mem_half_full = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Backpressure on a read response.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 5'd12; mem_empty = 1'b0; mem_full = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    chk("bp_rsp_cycle", k, 3);
    held = rsp_data;
    chk("bp_rsp_data", held, 32'h12345678);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold_valid%0d", c), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp_hold_data%0d", c), rsp_data, held);
      chk($sformatf("bp_hold_ready%0d", c), {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, cmd_ready}, 32'd1);

    // Error counter saturation with rejected writes.
    wr_before = wr_seen;
    mem_full = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'd1; cmd_wdata = 32'hCAFE0000;
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      if (n == 253) chk("sat_reach_255", {24'd0, err_cnt}, 32'd255);
      if (n == 255) chk("sat_err_flag", {31'd0, rsp_err}, 32'd0);
    end
    chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
    chk("sat_no_write", wr_seen - wr_before, 0);
    mem_full = 1'b0;

    // Reset while waiting for read data.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 5'd5; mem_empty = 1'b0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_read_strobe", {31'd0, mem_rd_en}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst_n = 1'b1;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) k++;
    end
    chk("mid_reset_no_rsp", k, 0);
    chk("mid_reset_idle", {31'd0, cmd_ready}, 32'd1);

    chk("strobes_exclusive", both_seen, 0);
    chk("bus_zero_when_idle", idle_bus_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
# mem_initiator

Command-driven initiator for the 32x32 memory: accepts single read/write commands on a valid/ready front end, drives the memory's `wr_en`/`rd_en`/`addr`/`wr_data` pins, and returns read data on a valid/ready response channel. It sits between test/system masters and the memory, checks `full`/`empty` before issuing an access, and counts rejected accesses.

## Interface

**Parameters**
- `ADDR_W`, default 5: memory address width.
- `DATA_W`, default 32: data width.

**Ports**

Clock is `clk`; reset is `rst_n`, synchronous and active-low.

- `clk` in 1: sole clock, all logic on posedge.
- `rst_n` in 1: synchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: initiator can accept a command.
- `cmd_we` in 1: 1 means write, 0 means read.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in DATA_W: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumer ready.
- `rsp_data` out DATA_W: read data (0 for writes and errors).
- `rsp_err` out 1: access rejected (write while full, or read while empty).
- `mem_wr_en` out 1: memory write strobe.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out ADDR_W: memory address.
- `mem_wr_data` out DATA_W: memory write data.
- `mem_data_out` in DATA_W: memory read data, valid the cycle after `mem_rd_en`.
- `mem_full` in 1: memory full flag.
- `mem_empty` in 1: memory empty flag.
- `mem_half_full` in 1: memory half-full flag, passed through to `half_full`.
- `half_full` out 1: registered copy of `mem_half_full`.
- `err_cnt` out 8: saturating count of rejected commands.

## Operation

- **FSM states:** IDLE, WRITE, READ, WAIT_RD, RSP.
- **IDLE:** `cmd_ready=1`. On `cmd_valid && cmd_ready`, latch `cmd_we`, `cmd_addr` and `cmd_wdata`.
  - Write with `mem_full=1` in the accept cycle: go to RSP with `rsp_err=1`, `rsp_data=0`. No `mem_wr_en` is issued.
  - Read with `mem_empty=1` in the accept cycle: go to RSP with `rsp_err=1`, `rsp_data=0`. No `mem_rd_en` is issued.
  - Otherwise: go to WRITE or READ.
- **WRITE:** `mem_wr_en=1`, `mem_addr`/`mem_wr_data` = latched values, for exactly one cycle. Next state is RSP (`rsp_data=0`, `rsp_err=0`) or IDLE, depending on Configuration.
- **READ:** `mem_rd_en=1`, `mem_addr` = latched address, for exactly one cycle. Next state is WAIT_RD.
- **WAIT_RD:** capture `mem_data_out` into `rsp_data` at the end of this cycle, then go to RSP.
- **RSP:** `rsp_valid=1`. `rsp_data` and `rsp_err` are held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `cmd_ready=0` in every state except IDLE. There is at most one command in flight.
- `mem_wr_en` and `mem_rd_en` are never high in the same cycle.
- `mem_addr` and `mem_wr_data` are driven to 0 when no strobe is active.
- **err_cnt:** increments on each rejected command at the accept edge, and saturates at 255.
- **Reset** (`rst_n` low at a posedge), including mid-operation:
  - State goes to IDLE; the in-flight command is dropped and no response is produced.
  - `cmd_ready`, `rsp_valid`, `rsp_data`, `rsp_err`, `mem_wr_en`, `mem_rd_en`, `mem_addr`, `mem_wr_data`, `half_full` and `err_cnt` are all 0.
  - `cmd_ready` is forced to 0 while `rst_n` is low.

## Timing

- **Write:** accept at edge T; `mem_wr_en` high during cycle T+1; `rsp_valid` high from T+2.
- **Read:** accept at T; `mem_rd_en` during T+1; `mem_data_out` sampled at the end of T+2; `rsp_valid` from T+3.
- **Rejected command:** `rsp_valid` from T+1.
- **Back-to-back throughput:** the next command can be accepted the cycle after the response handshake, giving a minimum of 3 cycles per write and 4 per read with `rsp_ready` tied high.
- `half_full` lags `mem_half_full` by one cycle.

## Configuration

- **`MEM_INIT_WR_RSP_EN` defined:** successful writes produce a response (WRITE goes to RSP, with `rsp_data=0` and `rsp_err=0`).
- **`MEM_INIT_WR_RSP_EN` undefined:** successful writes go from WRITE straight to IDLE with no response, so `cmd_ready` returns high in cycle T+2. Rejected writes still produce an error response.

## Test plan

- **Reset:** hold `rst_n=0` for 2 cycles with `cmd_valid=1`.
  - Expect all outputs 0 and `mem_wr_en`/`mem_rd_en` never asserted.
  - The cycle after release, expect `cmd_ready=1`.
- **Write then read:** write addr 5, data 0xDEADBEEF (`mem_full=0`), then read addr 5 with memory model returning 0xDEADBEEF.
  - Expect `mem_wr_en` at T+1 with `mem_addr=5`.
  - Expect read `rsp_valid` at T+3 with `rsp_data=0xDEADBEEF` and `rsp_err=0`.
- **Read while empty:** read with `mem_empty=1`.
  - Expect no `mem_rd_en`.
  - Expect `rsp_valid` at T+1 with `rsp_data=0`, `rsp_err=1`, and `err_cnt=1`.
- **Write while full:** write with `mem_full=1`.
  - Expect no `mem_wr_en` and `rsp_err=1`.
  - After 256 such commands, expect `err_cnt=255`.
- **Backpressure:** read succeeds with data 0x12345678 and `rsp_ready=0` for 5 cycles.
  - Expect `rsp_valid`/`rsp_data` held stable and `cmd_ready=0` throughout.
  - Expect return to IDLE one cycle after `rsp_ready=1`.
- **Reset mid-read:** assert `rst_n=0` during WAIT_RD.
  - Expect no response.
  - Expect state IDLE and all outputs 0 on the next cycle.
